// File: rtl/mdu_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mdu_controller_pkg
// Brief   : Shared types for the multiply/divide unit (op codes, FSM states).
// Revision: 1.0
// ============================================================================
package mdu_controller_pkg;

  localparam int MDU_DATA_WIDTH = 32;
  localparam int MDU_ITER       = MDU_DATA_WIDTH;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MFHI  = 3'd4,
    MDU_MFLO  = 3'd5,
    MDU_MTHI  = 3'd6,
    MDU_MTLO  = 3'd7
  } MduOp;

  typedef enum logic [1:0] {
    MDU_IDLE  = 2'd0,
    MDU_RUN   = 2'd1,
    MDU_FIXUP = 2'd2
  } MduState;

endpackage
`default_nettype wire

// File: rtl/mdu_shift_step.sv
`default_nettype none
// ============================================================================
// Module  : mdu_shift_step
// Brief   : One combinational iteration of shift-add multiply / shift-subtract divide.
// Revision: 1.0
// ============================================================================
module mdu_shift_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_div,
  input  logic [DATA_WIDTH-1:0] i_acc,
  input  logic [DATA_WIDTH-1:0] i_work,
  input  logic [DATA_WIDTH-1:0] i_opnd,
  output logic [DATA_WIDTH-1:0] o_acc,
  output logic [DATA_WIDTH-1:0] o_work
);

  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_trial;
  logic [DATA_WIDTH-1:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, i_acc} + (i_work[0] ? {1'b0, i_opnd} : '0);
    w_trial = {i_acc, i_work[DATA_WIDTH-1]};
    // Remainder stays below the divisor, so the low bits of the difference suffice.
    w_diff  = w_trial[DATA_WIDTH-1:0] - i_opnd;
    o_acc   = w_sum[DATA_WIDTH:1];
    o_work  = {w_sum[0], i_work[DATA_WIDTH-1:1]};
    if (i_div) begin
      if (w_trial >= {1'b0, i_opnd}) begin
        o_acc  = w_diff;
        o_work = {i_work[DATA_WIDTH-2:0], 1'b1};
      end else begin
        o_acc  = w_trial[DATA_WIDTH-1:0];
        o_work = {i_work[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu_controller.sv
`default_nettype none
// ============================================================================
// Module  : mdu_controller
// Brief   : Multi-cycle MULT/DIV sequencer owning HI/LO, with stall and flush handling.
// Revision: 1.0
// ============================================================================
module mdu_controller
  import mdu_controller_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_ITER,
  parameter bit FAST_DIV0  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_rs,
  input  logic [DATA_WIDTH-1:0] i_rt,
  input  logic                  i_flush,
  output logic                  o_ready,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_done,
  output logic                  o_busy
);

  localparam int C_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  MduState               r_state, w_state_nxt;
  logic [C_CNT_W-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0] r_hi, r_lo, r_acc, r_work, r_opnd;
  logic                  r_is_div, r_neg_res, r_neg_rem, r_div0;

  MduOp                  w_op;
  logic                  w_idle, w_accept, w_is_mul, w_is_div, w_signed;
  logic                  w_rs_neg, w_rt_neg, w_rt_zero, w_fast0;
  logic [DATA_WIDTH-1:0] w_rs_abs, w_rt_abs;
  logic [DATA_WIDTH-1:0] w_step_acc, w_step_work;
  logic [2*DATA_WIDTH-1:0] w_prod_fix;
  logic [DATA_WIDTH-1:0] w_quot_fix, w_rem_fix, w_res_hi, w_res_lo;

  assign w_op      = MduOp'(i_op);
  assign w_idle    = (r_state == MDU_IDLE);
  assign w_accept  = i_valid & w_idle & ~i_flush;
  assign w_is_mul  = (w_op == MDU_MULT) | (w_op == MDU_MULTU);
  assign w_is_div  = (w_op == MDU_DIV)  | (w_op == MDU_DIVU);
  assign w_signed  = (w_op == MDU_MULT) | (w_op == MDU_DIV);
  assign w_rs_neg  = w_signed & i_rs[DATA_WIDTH-1];
  assign w_rt_neg  = w_signed & i_rt[DATA_WIDTH-1];
  assign w_rs_abs  = w_rs_neg ? -i_rs : i_rs;
  assign w_rt_abs  = w_rt_neg ? -i_rt : i_rt;
  assign w_rt_zero = (i_rt == '0);
  assign w_fast0   = FAST_DIV0 & w_is_div & w_rt_zero;

  mdu_shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .i_div  (r_is_div),
    .i_acc  (r_acc),
    .i_work (r_work),
    .i_opnd (r_opnd),
    .o_acc  (w_step_acc),
    .o_work (w_step_work)
  );

  // Divide-by-zero leaves |rs| in the remainder path, so the normal remainder sign fix yields rs.
  assign w_prod_fix = r_neg_res ? -{r_acc, r_work} : {r_acc, r_work};
  assign w_quot_fix = r_div0 ? '1 : (r_neg_res ? -r_work : r_work);
  assign w_rem_fix  = r_neg_rem ? -r_acc : r_acc;
  assign w_res_hi   = r_is_div ? w_rem_fix  : w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_res_lo   = r_is_div ? w_quot_fix : w_prod_fix[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= MDU_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = w_idle;
    o_busy      = ~w_idle;
    o_done      = (r_state == MDU_FIXUP) & ~i_flush;
    o_stall     = i_valid & ~w_idle;
    o_rd_data   = '0;
    if (i_valid && w_idle) begin
      if (w_op == MDU_MFHI) o_rd_data = r_hi;
      if (w_op == MDU_MFLO) o_rd_data = r_lo;
    end
    case (r_state)
      MDU_IDLE:  if (w_accept && (w_is_mul || w_is_div))
                   w_state_nxt = w_fast0 ? MDU_FIXUP : MDU_RUN;
      MDU_RUN:   if (r_cnt == '0) w_state_nxt = MDU_FIXUP;
      MDU_FIXUP: w_state_nxt = MDU_IDLE;
      default:   w_state_nxt = MDU_IDLE;
    endcase
    if (i_flush && !w_idle) w_state_nxt = MDU_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_acc     <= '0;
      r_work    <= '0;
      r_opnd    <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      case (r_state)
        MDU_IDLE: if (w_accept) begin
          if (w_op == MDU_MTHI) r_hi <= i_rs;
          if (w_op == MDU_MTLO) r_lo <= i_rs;
          if (w_is_mul || w_is_div) begin
            r_cnt     <= C_CNT_W'(DATA_WIDTH - 1);
            r_opnd    <= w_rt_abs;
            r_acc     <= w_fast0 ? w_rs_abs : '0;
            r_work    <= w_rs_abs;
            r_is_div  <= w_is_div;
            r_neg_res <= w_rs_neg ^ w_rt_neg;
            r_neg_rem <= w_rs_neg;
            r_div0    <= w_is_div & w_rt_zero;
          end
        end
        MDU_RUN: if (!i_flush) begin
          r_acc  <= w_step_acc;
          r_work <= w_step_work;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        MDU_FIXUP: if (!i_flush) begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
